// File: rtl/disp_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// blank code, active-high glyph table and the digit-index type.
package disp_scan_pkg;

   localparam logic [3:0] BLK = 4'hF;

   typedef enum logic [1:0] {
      DigLeft  = 2'd0,
      DigMid   = 2'd1,
      DigRight = 2'd2
   } dig_idx_e;

   // Segment order {g,f,e,d,c,b,a}, entry 15 first.
   localparam logic [15:0][6:0] GLYPH_TAB = {
      7'h00, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [3:0] dig_code(logic [11:0] codes, dig_idx_e idx);
      logic [3:0] code;
      code = BLK;
      unique case (idx)
         DigLeft:  code = codes[11:8];
         DigMid:   code = codes[7:4];
         DigRight: code = codes[3:0];
         default:  code = BLK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit code to active-high {g,f,e,d,c,b,a} glyph lookup.
module seg7_glyph
   import disp_scan_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = GLYPH_TAB[code];
      if (code == BLK) glyph = '0;
   end

endmodule

// File: rtl/disp_scan.sv
// Three-digit multiplexed 7-segment scanner with dead-time blanking,
// PWM-style brightness and a frame-synchronous shadow of the digit codes.
module disp_scan
   import disp_scan_pkg::*;
#(
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned DEAD        = 16,
   parameter bit          COM_ACT_LOW = 1'b1,
   parameter bit          SEG_ACT_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] iDECO,
   input  logic        iEN,
   input  logic [2:0]  iBRIGHT,
   output logic [6:0]  oSEG,
   output logic [2:0]  oCOM,
   output logic        oFRAME
);

   localparam logic [DIV_W-1:0] DEAD_CNT = DIV_W'(DEAD);
   localparam logic [2:0]       COM_OFF  = COM_ACT_LOW ? 3'b111 : 3'b000;
   localparam logic [6:0]       SEG_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;

   logic [DIV_W-1:0] pcnt_q, pcnt_d;
   dig_idx_e         idx_q, idx_d;
   logic [11:0]      shadow_q, shadow_d;
   logic [2:0]       bright_q, bright_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       com_q, com_d;
   logic             frame_q;

   logic       tc;
   logic       load;
   logic       lit;
   logic [2:0] com_sel;
   logic [3:0] code;
   logic [6:0] glyph;

   seg7_glyph u_glyph (
      .code  (code),
      .glyph (glyph)
   );

   always_comb begin
      tc       = &pcnt_q;
      load     = tc && (idx_q == DigRight);
      pcnt_d   = pcnt_q + 1'b1;
      idx_d    = idx_q;
      com_sel  = 3'b000;
      shadow_d = load ? iDECO : shadow_q;
      bright_d = load ? iBRIGHT : bright_q;
      code     = dig_code(shadow_q, idx_q);

      unique case (idx_q)
         DigLeft: begin
            com_sel = 3'b100;
            if (tc) idx_d = DigMid;
         end
         DigMid: begin
            com_sel = 3'b010;
            if (tc) idx_d = DigRight;
         end
         DigRight: begin
            com_sel = 3'b001;
            if (tc) idx_d = DigLeft;
         end
         default: idx_d = DigLeft;
      endcase

      // Top three prescaler bits act as the brightness PWM phase.
      lit = iEN && (pcnt_q >= DEAD_CNT) && (pcnt_q[DIV_W-1 -: 3] <= bright_q);

      com_d = lit ? com_sel : 3'b000;
      seg_d = lit ? glyph : 7'h00;
      if (COM_ACT_LOW) com_d = ~com_d;
      if (SEG_ACT_LOW) seg_d = ~seg_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt_q   <= '0;
         idx_q    <= DigLeft;
         shadow_q <= 12'hFFF;
         bright_q <= 3'd7;
         com_q    <= COM_OFF;
         seg_q    <= SEG_OFF;
         frame_q  <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         bright_q <= bright_d;
         com_q    <= com_d;
         seg_q    <= seg_d;
         frame_q  <= load;
      end
   end

   assign oSEG   = seg_q;
   assign oCOM   = com_q;
   assign oFRAME = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIV_W=4, DEAD=2, active-low pins.
module tb_disp_scan;

   logic        clk;
   logic        rst;
   logic [11:0] iDECO;
   logic        iEN;
   logic [2:0]  iBRIGHT;
   logic [6:0]  oSEG;
   logic [2:0]  oCOM;
   logic        oFRAME;

   int checks;
   int failures;
   int ecount;

   disp_scan #(
      .DIV_W       (4),
      .DEAD        (2),
      .COM_ACT_LOW (1'b1),
      .SEG_ACT_LOW (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .iDECO   (iDECO),
      .iEN     (iEN),
      .iBRIGHT (iBRIGHT),
      .oSEG    (oSEG),
      .oCOM    (oCOM),
      .oFRAME  (oFRAME)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ecount = rising edges since reset release; sampling happens on falling edges.
   task automatic adv_to(input int k);
      while (ecount < k) begin
         @(negedge clk);
         ecount++;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      ecount = 0;
   endtask

   task automatic test_reset();
      iDECO = 12'h123; iEN = 1'b1; iBRIGHT = 3'd7;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (oCOM !== 3'b111 || oSEG !== 7'h7F || oFRAME !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold com=%b seg=%h frame=%b required com=111 seg=7f frame=0",
                  oCOM, oSEG, oFRAME);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (oCOM !== 3'b111 || oSEG !== 7'h7F || oFRAME !== 1'b0) begin
         failures++;
         $display("FAIL reset_held com=%b seg=%h frame=%b required com=111 seg=7f frame=0",
                  oCOM, oSEG, oFRAME);
      end
      rst = 1'b1;
      ecount = 0;
      adv_to(1);
      checks++;
      if (oCOM !== 3'b111) begin
         failures++;
         $display("FAIL reset_dead com=%b required 111", oCOM);
      end
      adv_to(3);
      checks++;
      if (oCOM !== 3'b011 || oSEG !== 7'h7F) begin
         failures++;
         $display("FAIL reset_blank_left com=%b seg=%h required com=011 seg=7f", oCOM, oSEG);
      end
      for (int k = 4; k <= 48; k++) begin
         adv_to(k);
         checks++;
         if (oSEG !== 7'h7F) begin
            failures++;
            $display("FAIL reset_blank k=%0d seg=%h required 7f", k, oSEG);
         end
         checks++;
         if (oFRAME !== (k == 48)) begin
            failures++;
            $display("FAIL reset_frame k=%0d frame=%b required %b", k, oFRAME, k == 48);
         end
      end
      adv_to(49);
      checks++;
      if (oFRAME !== 1'b0) begin
         failures++;
         $display("FAIL reset_frame_width frame=%b required 0", oFRAME);
      end
   endtask

   task automatic test_full_bright();
      logic [2:0] com_exp [3];
      logic [6:0] seg_exp [3];
      logic [2:0] ce;
      logic [6:0] se;
      com_exp = '{3'b011, 3'b101, 3'b110};
      seg_exp = '{7'b1111001, 7'b0100100, 7'b0110000};
      iDECO = 12'h123; iEN = 1'b1; iBRIGHT = 3'd7;
      apply_reset();
      for (int s = 0; s < 3; s++) begin
         for (int p = 0; p < 16; p++) begin
            adv_to(49 + 16 * s + p);
            ce = (p < 2) ? 3'b111 : com_exp[s];
            se = (p < 2) ? 7'h7F : seg_exp[s];
            checks++;
            if (oCOM !== ce || oSEG !== se) begin
               failures++;
               $display("FAIL full_bright slot=%0d pcnt=%0d com=%b seg=%b required com=%b seg=%b",
                        s, p, oCOM, oSEG, ce, se);
            end
         end
      end
   endtask

   task automatic test_tearing();
      iDECO = 12'h123; iEN = 1'b1; iBRIGHT = 3'd7;
      apply_reset();
      adv_to(70);
      iDECO = 12'h456;
      adv_to(86);
      checks++;
      if (oCOM !== 3'b110 || oSEG !== 7'b0110000) begin
         failures++;
         $display("FAIL tear_old_right com=%b seg=%b required com=110 seg=0110000", oCOM, oSEG);
      end
      adv_to(96);
      checks++;
      if (oFRAME !== 1'b1 || oSEG !== 7'b0110000) begin
         failures++;
         $display("FAIL tear_frame frame=%b seg=%b required frame=1 seg=0110000", oFRAME, oSEG);
      end
      adv_to(102);
      checks++;
      if (oCOM !== 3'b011 || oSEG !== 7'b0011001) begin
         failures++;
         $display("FAIL tear_new_left com=%b seg=%b required com=011 seg=0011001", oCOM, oSEG);
      end
      adv_to(118);
      checks++;
      if (oCOM !== 3'b101 || oSEG !== 7'b0010010) begin
         failures++;
         $display("FAIL tear_new_mid com=%b seg=%b required com=101 seg=0010010", oCOM, oSEG);
      end
      adv_to(134);
      checks++;
      if (oCOM !== 3'b110 || oSEG !== 7'b0000010) begin
         failures++;
         $display("FAIL tear_new_right com=%b seg=%b required com=110 seg=0000010", oCOM, oSEG);
      end
   endtask

   task automatic test_dimming();
      int on_cnt;
      logic [2:0] ce;
      iDECO = 12'h123; iEN = 1'b1; iBRIGHT = 3'd3;
      apply_reset();
      on_cnt = 0;
      for (int p = 0; p < 16; p++) begin
         adv_to(49 + p);
         ce = (p >= 2 && p <= 7) ? 3'b011 : 3'b111;
         if (oCOM === 3'b011) on_cnt++;
         checks++;
         if (oCOM !== ce) begin
            failures++;
            $display("FAIL dim3 pcnt=%0d com=%b required %b", p, oCOM, ce);
         end
      end
      checks++;
      if (on_cnt != 6) begin
         failures++;
         $display("FAIL dim3_count on=%0d required 6", on_cnt);
      end
      iBRIGHT = 3'd0;
      for (int k = 97; k <= 144; k++) begin
         adv_to(k);
         checks++;
         if (oCOM !== 3'b111) begin
            failures++;
            $display("FAIL dim0 k=%0d com=%b required 111", k, oCOM);
         end
      end
   endtask

   task automatic test_blank_enable();
      iDECO = 12'hF5F; iEN = 1'b1; iBRIGHT = 3'd7;
      apply_reset();
      adv_to(53);
      checks++;
      if (oCOM !== 3'b011 || oSEG !== 7'h7F) begin
         failures++;
         $display("FAIL blank_left com=%b seg=%h required com=011 seg=7f", oCOM, oSEG);
      end
      adv_to(69);
      checks++;
      if (oCOM !== 3'b101 || oSEG !== 7'b0010010) begin
         failures++;
         $display("FAIL blank_mid com=%b seg=%b required com=101 seg=0010010", oCOM, oSEG);
      end
      adv_to(85);
      checks++;
      if (oCOM !== 3'b110 || oSEG !== 7'h7F) begin
         failures++;
         $display("FAIL blank_right com=%b seg=%h required com=110 seg=7f", oCOM, oSEG);
      end
      adv_to(96);
      iEN = 1'b0;
      for (int k = 97; k <= 192; k++) begin
         adv_to(k);
         checks++;
         if (oCOM !== 3'b111 || oSEG !== 7'h7F) begin
            failures++;
            $display("FAIL en_off k=%0d com=%b seg=%h required com=111 seg=7f", k, oCOM, oSEG);
         end
         checks++;
         if (oFRAME !== (k == 144 || k == 192)) begin
            failures++;
            $display("FAIL en_off_frame k=%0d frame=%b required %b", k, oFRAME,
                     (k == 144 || k == 192));
         end
      end
      iEN = 1'b1;
   endtask

   task automatic test_mid_reset();
      iDECO = 12'h123; iEN = 1'b1; iBRIGHT = 3'd7;
      apply_reset();
      adv_to(73);
      checks++;
      if (oCOM !== 3'b101 || oSEG !== 7'b0100100) begin
         failures++;
         $display("FAIL mid_before com=%b seg=%b required com=101 seg=0100100", oCOM, oSEG);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (oCOM !== 3'b111 || oSEG !== 7'h7F || oFRAME !== 1'b0) begin
         failures++;
         $display("FAIL mid_abort com=%b seg=%h frame=%b required com=111 seg=7f frame=0",
                  oCOM, oSEG, oFRAME);
      end
      @(negedge clk);
      rst = 1'b1;
      ecount = 0;
      adv_to(3);
      checks++;
      if (oCOM !== 3'b011 || oSEG !== 7'h7F) begin
         failures++;
         $display("FAIL mid_restart_left com=%b seg=%h required com=011 seg=7f", oCOM, oSEG);
      end
      adv_to(20);
      checks++;
      if (oCOM !== 3'b101 || oSEG !== 7'h7F) begin
         failures++;
         $display("FAIL mid_restart_mid com=%b seg=%h required com=101 seg=7f", oCOM, oSEG);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      ecount   = 0;
      rst      = 1'b0;
      iDECO    = 12'h000;
      iEN      = 1'b0;
      iBRIGHT  = 3'd0;
      test_reset();
      test_full_bright();
      test_tearing();
      test_dimming();
      test_blank_enable();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
